// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants and helpers for the CNN front-end blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int CNN_DATA_WIDTH_MIN = 8;
    localparam int CNN_DATA_WIDTH_MAX = 32;
    localparam int CNN_NUM_LINES_MIN  = 2;
    localparam int CNN_NUM_LINES_MAX  = 8;

    // Ceiling log2; values of 0 and 1 both yield 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/sdp_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_line_ram
//  Description : Simple dual-port line RAM, one write port and one registered
//                read port with read-first behaviour on address collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_line_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Both ports live in one process so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : sdp_line_ram
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_window_buffer
//  Description : Stores K-1 video lines and emits a K-tall vertical pixel
//                column (oldest row first) for every pixel of line K-1 onward.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_window_buffer
    import cnn_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_LINES  = 3,
    parameter  int MAX_WIDTH  = 1024,
    localparam int ADDR_WIDTH = clog2(MAX_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_WIDTH:0]             line_width,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_sof,
    input  logic                            s_eol,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_LINES*DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0]           m_col,
    output logic                            m_eol,
    output logic                            err_eol
);

    localparam int STORED     = NUM_LINES - 1;
    localparam int SLOT_WIDTH = (STORED > 1) ? clog2(STORED) : 1;
    localparam int FILL_WIDTH = clog2(NUM_LINES);
    localparam int WIDTH_W    = ADDR_WIDTH + 1;

    if (DATA_WIDTH < CNN_DATA_WIDTH_MIN || DATA_WIDTH > CNN_DATA_WIDTH_MAX ||
        NUM_LINES  < CNN_NUM_LINES_MIN  || NUM_LINES  > CNN_NUM_LINES_MAX) begin : g_param_check
        $error("line_window_buffer: DATA_WIDTH or NUM_LINES out of range");
    end

    logic [ADDR_WIDTH-1:0] r_col;
    logic [SLOT_WIDTH-1:0] r_slot;
    logic [FILL_WIDTH-1:0] r_filled;
    logic [WIDTH_W-1:0]    r_width;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_pix;
    logic [SLOT_WIDTH-1:0] r_out_slot;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_col_eff;
    logic [SLOT_WIDTH-1:0] w_slot_eff;
    logic [SLOT_WIDTH-1:0] w_slot_next;
    logic [FILL_WIDTH-1:0] w_filled_eff;
    logic [WIDTH_W-1:0]    w_width_in;
    logic [WIDTH_W-1:0]    w_width_eff;
    logic                  w_last_col;
    logic                  w_line_end;
    logic                  w_full;

    logic [DATA_WIDTH-1:0]        w_rd_data [STORED];
    logic [STORED*DATA_WIDTH-1:0] w_rows_flat;

    assign s_ready  = rst_n && (!m_valid || m_ready);
    assign w_accept = s_valid && s_ready;
    assign err_eol  = r_err;

    // A start-of-frame beat restarts geometry in the same cycle it is accepted.
    assign w_width_in   = (line_width == '0) ? WIDTH_W'(1) : line_width;
    assign w_col_eff    = s_sof ? '0 : r_col;
    assign w_slot_eff   = s_sof ? '0 : r_slot;
    assign w_filled_eff = s_sof ? '0 : r_filled;
    assign w_width_eff  = s_sof ? w_width_in : r_width;

    assign w_last_col  = ({1'b0, w_col_eff} == (w_width_eff - WIDTH_W'(1)));
    assign w_line_end  = w_last_col || s_eol;
    assign w_full      = (w_filled_eff == FILL_WIDTH'(STORED));
    assign w_slot_next = (w_slot_eff == SLOT_WIDTH'(STORED - 1)) ? '0
                                                                 : w_slot_eff + SLOT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col    <= '0;
            r_slot   <= '0;
            r_filled <= '0;
            r_width  <= WIDTH_W'(MAX_WIDTH);
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_width <= w_width_eff;
            if (s_eol != w_last_col) begin
                r_err <= 1'b1;
            end
            if (w_line_end) begin
                r_col    <= '0;
                r_slot   <= w_slot_next;
                r_filled <= w_full ? w_filled_eff : w_filled_eff + FILL_WIDTH'(1);
            end else begin
                r_col    <= w_col_eff + ADDR_WIDTH'(1);
                r_slot   <= w_slot_eff;
                r_filled <= w_filled_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_col      <= '0;
            m_eol      <= 1'b0;
            r_pix      <= '0;
            r_out_slot <= '0;
        end else if (w_accept) begin
            m_valid    <= w_full;
            m_col      <= w_col_eff;
            m_eol      <= w_line_end;
            r_pix      <= s_data;
            r_out_slot <= w_slot_eff;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < STORED; g++) begin : g_line_ram
        sdp_line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk        (clk),
            .i_wr_en    (w_accept && (w_slot_eff == SLOT_WIDTH'(g))),
            .i_wr_addr  (w_col_eff),
            .i_wr_data  (s_data),
            .i_rd_en    (w_accept),
            .i_rd_addr  (w_col_eff),
            .o_rd_data  (w_rd_data[g])
        );
    end

    // The slot just overwritten held the oldest line; the rest follow in write order.
    always_comb begin
        w_rows_flat = '0;
        for (int r = 0; r < STORED; r++) begin
            for (int s = 0; s < STORED; s++) begin
                if (((int'(r_out_slot) + r) % STORED) == s) begin
                    w_rows_flat[r*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[s];
                end
            end
        end
    end

    // RAM read registers carry no reset, so the column is forced to zero while invalid.
    always_comb begin
        m_data = '0;
        if (m_valid) begin
            m_data = {r_pix, w_rows_flat};
        end
    end

endmodule : line_window_buffer
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_window_buffer
//  Description : Directed self-checking bench for line_window_buffer (K=3 and K=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_buffer;

    localparam int DW = 8;
    localparam int MW = 16;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW:0]     line_width = 5'd4;
    logic            s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0, m_ready = 1'b1;
    logic [DW-1:0]   s_data = '0;
    logic            s_ready, m_valid, m_eol, err_eol;
    logic [3*DW-1:0] m_data;
    logic [AW-1:0]   m_col;

    logic [AW:0]     line_width5 = 5'd1;
    logic            s_valid5 = 1'b0, s_sof5 = 1'b0, s_eol5 = 1'b0, m_ready5 = 1'b1;
    logic [DW-1:0]   s_data5 = '0;
    logic            s_ready5, m_valid5, m_eol5, err_eol5;
    logic [5*DW-1:0] m_data5;
    logic [AW-1:0]   m_col5;

    line_window_buffer #(.DATA_WIDTH(DW), .NUM_LINES(3), .MAX_WIDTH(MW)) dut3 (
        .clk(clk), .rst_n(rst_n), .line_width(line_width),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_col(m_col), .m_eol(m_eol),
        .err_eol(err_eol)
    );

    line_window_buffer #(.DATA_WIDTH(DW), .NUM_LINES(5), .MAX_WIDTH(MW)) dut5 (
        .clk(clk), .rst_n(rst_n), .line_width(line_width5),
        .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5), .s_sof(s_sof5), .s_eol(s_eol5),
        .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5), .m_col(m_col5), .m_eol(m_eol5),
        .err_eol(err_eol5)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3*DW-1:0] q_data[$];
    logic [AW-1:0]   q_col[$];
    logic            q_eol[$];
    logic [5*DW-1:0] q5[$];
    bit              toggle_en = 1'b0;

    logic            stalled_prev = 1'b0;
    logic [3*DW-1:0] prev_data;
    logic [AW-1:0]   prev_col;
    logic            prev_eol;

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 m_ready = ~m_ready;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                chk("hold_valid", {63'd0, m_valid}, 64'd1);
                chk("hold_data", {40'd0, m_data}, {40'd0, prev_data});
                chk("hold_col", {60'd0, m_col}, {60'd0, prev_col});
                chk("hold_eol", {63'd0, m_eol}, {63'd0, prev_eol});
            end
            if (m_valid && m_ready) begin
                q_data.push_back(m_data);
                q_col.push_back(m_col);
                q_eol.push_back(m_eol);
            end
            if (m_valid && !m_ready) begin
                chk("stall_s_ready", {63'd0, s_ready}, 64'd0);
            end
            stalled_prev = m_valid && !m_ready;
            prev_data    = m_data;
            prev_col     = m_col;
            prev_eol     = m_eol;
            if (m_valid5 && m_ready5) begin
                q5.push_back(m_data5);
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic sof, input logic eol);
        int n;
        n = 0;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", {63'd0, s_ready}, 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    task automatic push5(input logic [7:0] d, input logic sof, input logic eol);
        int n;
        n = 0;
        s_valid5 = 1'b1; s_data5 = d; s_sof5 = sof; s_eol5 = eol;
        @(negedge clk);
        while (!s_ready5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push5_timeout", {63'd0, s_ready5}, 64'd1);
        @(posedge clk); #1;
        s_valid5 = 1'b0; s_sof5 = 1'b0; s_eol5 = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete(); q_col.delete(); q_eol.delete(); q5.delete();
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Pixel value of line L column c is base + 4L + c.
    task automatic push_frame_w4(input logic [7:0] base);
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 4; c++) begin
                push(base + 8'(4 * l + c), (l == 0 && c == 0), (c == 3));
            end
        end
    endtask

    task automatic check_frame_w4(input string tag, input logic [7:0] base);
        logic [7:0] p0, p1, p2;
        int l, c;
        chk({tag, "_count"}, 64'(q_data.size()), 64'd8);
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            l  = 2 + i / 4;
            c  = i % 4;
            p2 = base + 8'(4 * l + c);
            p1 = base + 8'(4 * (l - 1) + c);
            p0 = base + 8'(4 * (l - 2) + c);
            chk({tag, "_data"}, {40'd0, q_data[i]}, {40'd0, p2, p1, p0});
            chk({tag, "_col"}, {60'd0, q_col[i]}, 64'(c));
            chk({tag, "_eol"}, {63'd0, q_eol[i]}, {63'd0, (c == 3)});
        end
    endtask

    initial begin
        logic [7:0] p0, p1, p2;
        int l, c;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", {40'd0, m_data}, 64'd0);
        chk("rst_m_col", {60'd0, m_col}, 64'd0);
        chk("rst_m_eol", {63'd0, m_eol}, 64'd0);
        chk("rst_err_eol", {63'd0, err_eol}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_s_ready5", {63'd0, s_ready5}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);

        // Basic frame, m_ready held high
        @(posedge clk); #1;
        clear_q();
        push_frame_w4(8'h00);
        drain();
        check_frame_w4("frame_a", 8'h00);

        // Same frame with m_ready toggling every cycle
        clear_q();
        toggle_en = 1'b1;
        push_frame_w4(8'h00);
        drain();
        @(posedge clk); #2;
        toggle_en = 1'b0;
        m_ready   = 1'b1;
        drain();
        check_frame_w4("frame_toggle", 8'h00);

        // Width-2 frame; line_width changes after sof must be ignored
        clear_q();
        line_width = 5'd2;
        for (int i = 0; i < 8; i++) begin
            push(8'h20 + 8'(i), (i == 0), (i % 2 == 1));
            line_width = 5'd7;
        end
        drain();
        chk("w2_count", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            l  = 2 + i / 2;
            c  = i % 2;
            p2 = 8'h20 + 8'(2 * l + c);
            p1 = 8'h20 + 8'(2 * (l - 1) + c);
            p0 = 8'h20 + 8'(2 * (l - 2) + c);
            chk("w2_data", {40'd0, q_data[i]}, {40'd0, p2, p1, p0});
            chk("w2_col", {60'd0, q_col[i]}, 64'(c));
            chk("w2_eol", {63'd0, q_eol[i]}, {63'd0, (c == 1)});
        end
        chk("err_clean", {63'd0, err_eol}, 64'd0);

        // Line 1 terminated early by s_eol at column 2
        clear_q();
        line_width = 5'd4;
        for (int ln = 0; ln < 4; ln++) begin
            for (int cc = 0; cc < ((ln == 1) ? 3 : 4); cc++) begin
                push(8'h40 + 8'(16 * ln + cc), (ln == 0 && cc == 0),
                     (ln == 1) ? (cc == 2) : (cc == 3));
            end
        end
        drain();
        chk("err_set", {63'd0, err_eol}, 64'd1);
        chk("err_count", 64'(q_data.size()), 64'd8);
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            l = 2 + i / 4;
            c = i % 4;
            chk("err_col", {60'd0, q_col[i]}, 64'(c));
            if (c < 3) begin
                p2 = 8'h40 + 8'(16 * l + c);
                p1 = 8'h40 + 8'(16 * (l - 1) + c);
                p0 = 8'h40 + 8'(16 * (l - 2) + c);
                chk("err_data", {40'd0, q_data[i]}, {40'd0, p2, p1, p0});
            end
        end
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", {63'd0, err_eol}, 64'd1);

        // Reset in the middle of line 2, then a fresh frame
        clear_q();
        for (int i = 0; i < 10; i++) begin
            push(8'(i), (i == 0), (i % 4 == 3));
        end
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("midrst_err", {63'd0, err_eol}, 64'd0);
        chk("midrst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("midrst_m_data", {40'd0, m_data}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_q();
        push_frame_w4(8'h00);
        drain();
        check_frame_w4("after_rst", 8'h00);

        // K=5 with one-pixel lines, sof and eol on the same beat
        clear_q();
        line_width5 = 5'd1;
        for (int i = 0; i < 6; i++) begin
            push5(8'(i), (i == 0), 1'b1);
        end
        drain();
        chk("k5_count", 64'(q5.size()), 64'd2);
        if (q5.size() >= 2) begin
            chk("k5_first", {24'd0, q5[0]}, {24'd0, 40'h04_03_02_01_00});
            chk("k5_second", {24'd0, q5[1]}, {24'd0, 40'h05_04_03_02_01});
        end
        chk("k5_err", {63'd0, err_eol5}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_line_window_buffer
`default_nettype wire

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width in bits (8..32).
REQ-002 SHALL have parameter NUM_LINES, default 3, window height K (2..8); K-1 lines are stored.
REQ-003 SHALL have parameter MAX_WIDTH, default 1024, maximum pixels per line; ADDR_WIDTH = clog2(MAX_WIDTH).
REQ-004 SHALL have port clk, input, 1, single clock for all logic; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port line_width, input, ADDR_WIDTH+1, pixels per line (1..MAX_WIDTH); sampled on accepted s_sof beat.
REQ-007 SHALL have ports s_valid/s_ready, input/output, 1 each, input pixel handshake.
REQ-008 SHALL have port s_data, input, DATA_WIDTH, input pixel.
REQ-009 SHALL have ports s_sof/s_eol, input, 1 each, first pixel of frame / last pixel of line.
REQ-010 SHALL have ports m_valid/m_ready, output/input, 1 each, column-output handshake.
REQ-011 SHALL have port m_data, output, NUM_LINES*DATA_WIDTH, vertical column; slice i = row i, i=0 oldest, i=K-1 current pixel.
REQ-012 SHALL have port m_col, output, ADDR_WIDTH, column index of m_data.
REQ-013 SHALL have port m_eol, output, 1, marks last column of a line.
REQ-014 SHALL have port err_eol, output, 1, sticky flag: s_eol disagreed with column count.

Function
REQ-015 SHALL accept a beat when s_valid && s_ready; s_ready = !m_valid || m_ready (single output register, no combinational s_valid->m_valid path).
REQ-016 SHALL write each accepted pixel into stored line slot wr_slot at address col, and in the same cycle read address col from all other K-2 slots plus the slot being overwritten (previous value, read-before-write).
REQ-017 SHALL present m_data one cycle after acceptance (latency 1), rotated so row ordering is oldest-first independent of wr_slot.
REQ-018 SHALL increment col per accepted beat; wrap col to 0 and advance wr_slot modulo K-1 when col == line_width-1 or s_eol is accepted.
REQ-019 SHALL set err_eol when s_eol and col != line_width-1 disagree; line still ends at whichever comes first.
REQ-020 SHALL count filled lines saturating at K-1; m_valid SHALL assert only for beats accepted while filled == K-1 (columns from the first K-1 lines of a frame are consumed but not output).
REQ-021 SHALL, on accepted s_sof, treat that beat as col 0 of line 0: filled=0, wr_slot=0, line_width relatched; stored RAM contents need not be cleared.
REQ-022 SHALL hold m_data/m_col/m_eol stable while m_valid && !m_ready.
REQ-023 SHALL handle s_sof && s_eol on the same beat (line_width=1) as a one-pixel line.
REQ-024 SHALL ignore line_width changes except at accepted s_sof; line_width=0 SHALL be treated as 1.

Reset
REQ-025 SHALL on rst_n low asynchronously clear m_valid, m_data, m_col, m_eol, err_eol, col, wr_slot, filled; latched width = MAX_WIDTH; s_ready low during reset, high first cycle after.
REQ-026 SHALL, on reset mid-frame, discard partial state; next output requires K-1 new full lines.

Structure
REQ-027 SHALL take clog2 function and DATA_WIDTH/NUM_LINES limits from shared package cnn_pkg.
REQ-028 SHALL instantiate K-1 copies of sub-module sdp_line_ram (one write port, one sync read port, read-first, depth MAX_WIDTH).
REQ-029 SHALL contain no vendor IP instance; sdp_line_ram is inferable RTL.

Verification
REQ-030 K=3, W=4, DATA=8, frame pixels 0x00..0x0F, m_ready=1 -> 8 outputs; first m_data={0x08,0x04,0x00} (row2..row0), m_col=0; last {0x0F,0x0B,0x07}, m_eol=1.
REQ-031 Same stimulus, m_ready toggled 1/0 every cycle -> identical output sequence, no drops/duplicates, s_ready low whenever output stalled.
REQ-032 Line 1 ends with s_eol at col 2 (W=4) -> err_eol=1 stays set; next line starts col 0.
REQ-033 Mid-line 2 assert rst_n=0, then new frame with s_sof -> no m_valid until line 2 of new frame; outputs match REQ-030 ordering.
REQ-034 K=5, W=1 with s_sof&&s_eol on beat 0 -> first m_valid on beat 4, m_data = beats {4,3,2,1,0}.
REQ-035 Second frame with line_width=2 on s_sof -> wrap at col 1, wr_slot rotation continues correctly, outputs oldest-first.
